mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter AW, default 10, meaning word-address width (memory depth 2^AW 32-bit words).
REQ-002 The block SHALL have parameter BASE, default 32'h0000_0000, meaning byte base address of the window; it is aligned to 4*2^AW.
REQ-003 The block SHALL have port clk  input  1  CPU clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port BUS  inout  32  shared data bus; driven by the block only during a serviced read.
REQ-006 The block SHALL have port Memread  input  1  read strobe, one cycle per access.
REQ-007 The block SHALL have port Memwrite  input  2  write command: 0 none, 1 word, 2 DMA fill, 3 byte.
REQ-008 The block SHALL have port Addr  input  32  byte address.
REQ-009 The block SHALL have port dma_busy  output  1  fill engine active.
REQ-010 The block SHALL have port dma_done  output  1  one-cycle pulse when a fill completes.
REQ-011 The block SHALL have port err  output  1  one-cycle pulse on a rejected access.

Function
REQ-012 The block SHALL define hit as Addr[31:AW+2]==BASE[31:AW+2] and index as Addr[AW+1:2].
REQ-013 Read: while Memread=1, hit and Memwrite=0, the block SHALL drive BUS combinationally with mem[index] rotated right by 8*Addr[1:0], so the addressed byte sits in BUS[7:0]; the CPU samples it on the next rising edge.
REQ-014 The block SHALL hold BUS at high-Z in every other case, including during reset.
REQ-015 Word write: on an edge with Memwrite=1 and hit, the block SHALL set mem[index]=BUS; Addr[1:0] is ignored.
REQ-016 Byte write: on an edge with Memwrite=3 and hit, the block SHALL write BUS[7:0] into byte lane Addr[1:0] of mem[index] and leave the other lanes unchanged.
REQ-017 On any edge with Memread=1 or Memwrite!=0 and no hit, the block SHALL pulse err and leave memory unchanged.
REQ-018 If Memread=1 and Memwrite!=0 together, the write SHALL execute, BUS SHALL NOT be driven, and err SHALL pulse.
REQ-019 The fill FSM SHALL have states IDLE and FILL.
REQ-020 IDLE->FILL: on an edge with Memwrite=2, hit and BUS[15:0]!=0, the block SHALL latch ptr=index and cnt=BUS[15:0].
REQ-021 If Memwrite=2 arrives with BUS[15:0]=0, the block SHALL treat it as a no-op: no err, no dma_done.
REQ-022 In FILL, on each edge the block SHALL set mem[ptr]=0, increment ptr modulo 2^AW (wraps at top of window), and decrement cnt.
REQ-023 On the edge that writes the last word the block SHALL return to IDLE and pulse dma_done on the following cycle.
REQ-024 dma_busy SHALL be 1 exactly while in FILL; a fill of N words SHALL keep dma_busy high for N cycles.
REQ-025 Memwrite=2 while in FILL SHALL be ignored and SHALL pulse err.
REQ-026 CPU reads and writes SHALL be serviced during FILL.
REQ-027 When a CPU write and a fill write hit the same index on the same edge, the CPU write SHALL win.
REQ-028 A read of a word not yet filled SHALL return its old value.

Reset
REQ-029 While rst=0, the block SHALL hold the FSM in IDLE with ptr=0, cnt=0, dma_busy=0, dma_done=0, err=0, and BUS high-Z.
REQ-030 Reset asserted mid-fill SHALL abort the fill; words already written keep their zero value and the rest are untouched.
REQ-031 Memory contents SHALL NOT be reset.

Configuration
REQ-032 With macro MEM_RESPONDER_DMA_EN defined, the block SHALL include the fill FSM, counter and ptr, and SHALL behave as REQ-019..REQ-028.
REQ-033 Without MEM_RESPONDER_DMA_EN, Memwrite=2 SHALL be a no-op that pulses err, dma_busy and dma_done SHALL be tied 0, and no fill logic SHALL be present.

Verification
REQ-034 The bench SHALL write word 32'hDEADBEEF to Addr 8, then read Addr 8 -> BUS=32'hDEADBEEF in the Memread cycle and high-Z the cycle after.
REQ-035 After the REQ-034 write, the bench SHALL byte-write BUS=32'h000000AA to Addr 9, then read Addr 9 -> BUS[7:0]=8'hAA and full word at Addr 8 = 32'hDEADAAEF.
REQ-036 The bench SHALL issue a fill with Addr=4*(2^AW-2) and BUS[15:0]=4 -> dma_busy high 4 cycles, words 1022, 1023, 0 and 1 zeroed, dma_done pulses once, word 2 unchanged.
REQ-037 The bench SHALL issue Memread at Addr=32'h0001_0000 (miss) -> err pulses 1 cycle and BUS stays high-Z; repeat with Memread=1 and Memwrite=1 together at a hit address -> write lands, err pulses.
REQ-038 The bench SHALL issue a fill of 8 words and drop rst after 3 cycles -> first 3 words zero, remaining 5 unchanged, dma_busy=0 immediately, no dma_done.
REQ-039 The bench SHALL build with MEM_RESPONDER_DMA_EN undefined and issue Memwrite=2 -> memory unchanged, err pulses, dma_busy stays 0.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-mapped 2^AW x 32-bit word window on a shared tristate bus, with an
// optional zero-fill engine compiled in by defining MEM_RESPONDER_DMA_EN.
module mem_responder #(
  parameter int          AW   = 10,
  parameter logic [31:0] BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] BUS,
  input  logic        Memread,
  input  logic [1:0]  Memwrite,
  input  logic [31:0] Addr,
  output logic        dma_busy,
  output logic        dma_done,
  output logic        err
);

  localparam logic [1:0] WR_NONE = 2'd0;
  localparam logic [1:0] WR_WORD = 2'd1;
  localparam logic [1:0] WR_FILL = 2'd2;
  localparam logic [1:0] WR_BYTE = 2'd3;

  logic [31:0]   mem [2**AW];
  logic          hit;
  logic [AW-1:0] index;
  logic [4:0]    lane_shift;
  logic [63:0]   word_pair;
  logic [31:0]   rd_data;
  logic          rd_en;
  logic          access;
  logic          word_we;
  logic          byte_we;
  logic          err_next;

  assign hit        = (Addr[31:AW+2] == BASE[31:AW+2]);
  assign index      = Addr[AW+1:2];
  assign lane_shift = {Addr[1:0], 3'b000};
  assign access     = Memread || (Memwrite != WR_NONE);
  assign word_we    = hit && (Memwrite == WR_WORD);
  assign byte_we    = hit && (Memwrite == WR_BYTE);

  // Duplicating the word turns the right-rotate into a plain shift.
  assign word_pair = {mem[index], mem[index]};
  assign rd_data   = 32'(word_pair >> lane_shift);
  assign rd_en     = rst && Memread && hit && (Memwrite == WR_NONE);
  assign BUS       = rd_en ? rd_data : 32'bz;

`ifdef MEM_RESPONDER_DMA_EN
  typedef enum logic {IDLE, FILL} state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_next;
  logic [15:0]   cnt;
  logic [15:0]   cnt_next;
  logic          fill_we;
  logic          fill_start;
  logic          done_next;

  assign fill_start = hit && (Memwrite == WR_FILL) && (BUS[15:0] != 16'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      dma_done <= 1'b0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      cnt      <= cnt_next;
      dma_done <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    cnt_next   = cnt;
    fill_we    = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) begin
          state_next = FILL;
          ptr_next   = index;
          cnt_next   = BUS[15:0];
        end
      end
      FILL: begin
        fill_we  = 1'b1;
        ptr_next = ptr + 1'b1;
        cnt_next = cnt - 1'b1;
        if (cnt == 16'd1) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign dma_busy = (state == FILL);
  assign err_next = (access && !hit) || (Memread && (Memwrite != WR_NONE))
                  || ((Memwrite == WR_FILL) && (state == FILL));
`else
  assign dma_busy = 1'b0;
  assign dma_done = 1'b0;
  assign err_next = (access && !hit) || (Memread && (Memwrite != WR_NONE))
                  || (Memwrite == WR_FILL);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else      err <= err_next;
  end

  // Fill write comes first so a same-index CPU write on this edge overrides it.
  always_ff @(posedge clk) begin
`ifdef MEM_RESPONDER_DMA_EN
    if (fill_we) mem[ptr] <= '0;
`endif
    if (word_we)      mem[index] <= BUS;
    else if (byte_we) mem[index][lane_shift +: 8] <= BUS[7:0];
  end

endmodule
